// File: rtl/lcd_hd44780_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_hd44780_sequencer
// Summary  : Converts LCD register command words into timed HD44780 parallel
//            bus write cycles (setup, enable pulse, hold, execution wait).
//            Provides a one-entry request buffer, a sticky drop flag and a
//            busy/status readback word.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_hd44780_sequencer #(
  parameter int T_POR       = 750000,
  parameter int T_SETUP     = 3,
  parameter int T_PW        = 12,
  parameter int T_HOLD      = 2,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 82000,
  parameter int CNT_W       = 20
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_lcd_word,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic        o_busy,
  output logic [31:0] o_status
);

  // Bit positions inside the LCD register word.
  localparam int c_RS_BIT  = 8;
  localparam int c_GO_BIT  = 10;
  localparam int c_CLR_BIT = 11;
  localparam int c_ON_BIT  = 31;

  // Each state lasts N cycles: the counter starts at 0 on entry and the
  // state is left when it reaches N-1.
  localparam logic [CNT_W-1:0] c_POR_LAST   = CNT_W'(T_POR - 1);
  localparam logic [CNT_W-1:0] c_SETUP_LAST = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] c_PW_LAST    = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0] c_HOLD_LAST  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] c_EXEC_LAST  = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] c_LONG_LAST  = CNT_W'(T_EXEC_LONG - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_POR_WAIT = 3'd0,
    S_IDLE     = 3'd1,
    S_SETUP    = 3'd2,
    S_PULSE    = 3'd3,
    S_HOLD     = 3'd4,
    S_EXEC     = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_exec_last;

  logic             r_go_q;
  logic             r_clr_q;
  logic             r_pend;
  logic [7:0]       r_pend_data;
  logic             r_pend_rs;
  logic             r_drop;
  logic [7:0]       r_lcd_data;
  logic             r_lcd_rs;
  logic             r_lcd_en;
  logic             r_lcd_on;

  logic             w_go_rise;
  logic             w_clr_rise;
  logic             w_start_in;
  logic             w_start_pend;
  logic             w_pend_wr;
  logic             w_drop_set;
  logic             w_exec_long;
  logic [7:0]       w_req_data;
  logic             w_req_rs;
  logic             w_unused_bits;

  // RW (bit 9) is ignored and bits 30:12 are reserved.
  assign w_unused_bits = ^{i_lcd_word[30:12], i_lcd_word[9]};

  assign w_req_data = i_lcd_word[7:0];
  assign w_req_rs   = i_lcd_word[c_RS_BIT];
  assign w_go_rise  = i_lcd_word[c_GO_BIT]  & ~r_go_q;
  assign w_clr_rise = i_lcd_word[c_CLR_BIT] & ~r_clr_q;

  // Clear and return-home (RS=0, data 0x01..0x03) need the long wait.
  assign w_exec_long = ~r_lcd_rs & (r_lcd_data[7:2] == 6'd0) & (r_lcd_data[1:0] != 2'd0);
  assign w_exec_last = w_exec_long ? c_LONG_LAST : c_EXEC_LAST;

  // A request not started directly goes to the buffer if it is free,
  // otherwise it is discarded and recorded in the drop flag.
  assign w_pend_wr  = w_go_rise & ~w_start_in & ~r_pend;
  assign w_drop_set = w_go_rise & r_pend;

  // State register and shared duration counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_POR_WAIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and counter reload; every transition restarts the counter.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + c_CNT_ONE;
    w_start_in   = 1'b0;
    w_start_pend = 1'b0;
    case (r_state)
      S_POR_WAIT: begin
        if (r_cnt == c_POR_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (r_pend) begin
          w_start_pend = 1'b1;
          w_state_nxt  = S_SETUP;
        end else if (w_go_rise) begin
          w_start_in  = 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (r_cnt == c_SETUP_LAST) begin
          w_state_nxt = S_PULSE;
          w_cnt_nxt   = '0;
        end
      end
      S_PULSE: begin
        if (r_cnt == c_PW_LAST) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
        end
      end
      S_HOLD: begin
        if (r_cnt == c_HOLD_LAST) begin
          w_state_nxt = S_EXEC;
          w_cnt_nxt   = '0;
        end
      end
      S_EXEC: begin
        if (r_cnt == w_exec_last) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_POR_WAIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Edge-detect history; GO history resets high so a held GO cannot fire.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_go_q  <= 1'b1;
      r_clr_q <= 1'b0;
    end else begin
      r_go_q  <= i_lcd_word[c_GO_BIT];
      r_clr_q <= i_lcd_word[c_CLR_BIT];
    end
  end

  // One-entry request buffer: filled by a deferred request, emptied in IDLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend      <= 1'b0;
      r_pend_data <= 8'd0;
      r_pend_rs   <= 1'b0;
    end else if (w_start_pend) begin
      r_pend <= 1'b0;
    end else if (w_pend_wr) begin
      r_pend      <= 1'b1;
      r_pend_data <= w_req_data;
      r_pend_rs   <= w_req_rs;
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear edge wins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_drop <= 1'b0;
    end else if (w_drop_set) begin
      r_drop <= 1'b1;
    end else if (w_clr_rise) begin
      r_drop <= 1'b0;
    end
  end

  // Bus data/RS load on entry to SETUP and are held until the next transfer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lcd_data <= 8'd0;
      r_lcd_rs   <= 1'b0;
    end else if (w_start_in) begin
      r_lcd_data <= w_req_data;
      r_lcd_rs   <= w_req_rs;
    end else if (w_start_pend) begin
      r_lcd_data <= r_pend_data;
      r_lcd_rs   <= r_pend_rs;
    end
  end

  // Registered strobe (glitch-free) and display power follower.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lcd_en <= 1'b0;
      r_lcd_on <= 1'b0;
    end else begin
      r_lcd_en <= (w_state_nxt == S_PULSE);
      r_lcd_on <= i_lcd_word[c_ON_BIT];
    end
  end

  assign o_lcd_data = r_lcd_data;
  assign o_lcd_rs   = r_lcd_rs;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = r_lcd_en;
  assign o_lcd_on   = r_lcd_on;
  assign o_busy     = (r_state != S_IDLE) | r_pend;
  assign o_status   = {29'd0, r_drop, r_pend, o_busy};

endmodule
`default_nettype wire

// File: doc/lcd_hd44780_sequencer.md
Name: lcd_hd44780_sequencer

Overview:
- Downstream consumer of the memory-mapped LCD output register (byte 0x7030 region) of the LSU output bank.
- Turns software-written command words into correctly timed HD44780 parallel-bus write cycles: RS/RW setup, EN pulse, hold, and per-command execution wait.
- Provides a busy/status word that the LSU input bank reads back, so firmware can poll before issuing the next command.

Parameters:
- T_POR, 750000, cycles to wait after reset before accepting commands (15 ms at 50 MHz).
- T_SETUP, 3, cycles RS/RW/DATA are stable before EN rises.
- T_PW, 12, cycles EN is held high.
- T_HOLD, 2, cycles DATA/RS are held after EN falls.
- T_EXEC, 2000, execution wait for normal commands and data writes (40 us).
- T_EXEC_LONG, 82000, execution wait for clear (0x01) and home (0x02/0x03) commands with RS=0 (1.64 ms).
- CNT_W, 20, width of the shared timing counter; must hold max(T_POR, T_EXEC_LONG).

Ports:
- i_clk, in, 1, system clock.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_lcd_word, in, 32, LCD register contents. Bit fields:
  - [7:0] data
  - [8] RS
  - [9] RW (ignored; bus is always driven as write)
  - [10] GO
  - [11] CLR_ERR
  - [31] display power ON
- o_lcd_data, out, 8, LCD data bus.
- o_lcd_rs, out, 1, register select.
- o_lcd_rw, out, 1, read/write; always 0.
- o_lcd_en, out, 1, enable strobe.
- o_lcd_on, out, 1, display power; registered copy of i_lcd_word[31].
- o_busy, out, 1, high whenever the block is not in IDLE or a request is pending.
- o_status, out, 32, readback word: {29'd0, o_drop, o_pending, o_busy}.

Behaviour:
- Reset (asynchronous, i_rst_n=0) forces:
  - state = POR_WAIT, counter = 0
  - o_lcd_data = 0, o_lcd_rs = 0, o_lcd_rw = 0, o_lcd_en = 0, o_lcd_on = 0
  - pending = 0, drop = 0
  - GO history register = 1, so a GO already set at reset release does not trigger.
- Reset asserted mid-transfer aborts immediately: EN drops asynchronously and no partial pulse is resumed.
- Request detection:
  - Rising edge of i_lcd_word[10], sampled against a registered copy = one request.
  - The request captures data[7:0] and RS[8] in the same cycle it is detected.
- Buffering: one-entry pending buffer.
  - Request arrives in IDLE with no pending entry → transfer starts next cycle.
  - Request arrives while busy and pending is empty → stored in pending.
  - Request arrives while pending is full → request discarded and drop sticky set.
- Drop flag:
  - Cleared by a rising edge of CLR_ERR, or by reset.
  - If a set event and a clear event land in the same cycle, set wins.
- State machine:
  - POR_WAIT: counts T_POR cycles, then goes to IDLE. Requests arriving during POR_WAIT go to pending under the same rules.
  - IDLE: if pending is set, pending is consumed (cleared) and the state goes to SETUP. Otherwise a new edge goes straight to SETUP.
  - SETUP: o_lcd_data/o_lcd_rs are driven from the captured values, EN = 0. Lasts T_SETUP cycles, then PULSE.
  - PULSE: EN = 1 for exactly T_PW cycles, then HOLD.
  - HOLD: EN = 0 with data/RS held for T_HOLD cycles, then EXEC.
  - EXEC: waits T_EXEC_LONG if RS=0 and data is in {0x01, 0x02, 0x03}, otherwise T_EXEC. Then IDLE.
- Data and RS outputs keep their last values in IDLE; they are never forced back to 0.
- Back-to-back timing: when pending is set at EXEC end, the next SETUP begins at most 1 cycle after EXEC ends (via IDLE).
- o_lcd_on follows i_lcd_word[31] with a 1-cycle register delay. It is independent of the state machine and is not gated by POR_WAIT.
- Counter: a single down/up counter is reloaded on each state entry. The duration of every state is exact; off-by-one is a test failure.

Test Plan (sim with T_POR=20, T_SETUP=3, T_PW=4, T_HOLD=2, T_EXEC=10, T_EXEC_LONG=40):
- Reset, hold GO=0 → o_busy=1 for exactly 20 cycles after reset release, then 0. All bus outputs stay 0.
- After POR, write data=0x41, RS=1, GO 0→1 → o_lcd_data=0x41 and rs=1 for 3 cycles before EN, EN high exactly 4 cycles, o_busy drops 2+10 cycles after EN falls.
- Write data=0x01, RS=0 → EXEC lasts 40 cycles. Repeat with 0x38 → EXEC lasts 10 cycles.
- Issue three GO edges during one transfer → the second is serviced immediately after the first, the third is dropped, o_status=0x5 during the second transfer. A CLR_ERR edge then gives o_status[2]=0.
- Assert i_rst_n=0 while EN=1 → EN=0 in the same cycle (asynchronous), pending and drop cleared, POR wait restarts.
- Hold GO=1 through reset release → no transfer is issued. Toggle GO 1→0→1 → exactly one transfer.
